// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encoding and stream word geometry.
package mips_pkg;
    typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERROR} loader_state_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words.
module word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        byteEn,
    input  logic [7:0]  byteIn,
    output logic        wordValid,
    output logic [31:0] word
);
    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);
    logic [1:0]  lane_q, lane_d;
    logic [23:0] pack_q, pack_d;
    // Only three bytes are stored; the fourth is taken straight from the bus.
    always_comb begin
        lane_d    = byteEn ? lane_q + 2'd1 : lane_q;
        pack_d    = byteEn ? {byteIn, pack_q[23:8]} : pack_q;
        wordValid = byteEn && (lane_q == LAST_LANE);
        word      = {byteIn, pack_q};
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lane_q <= 2'd0;
            pack_q <= 24'd0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time byte-stream loader for instruction memory; holds the CPU in reset until loaded.
// Define INST_LOADER_CHECKSUM_EN to require a trailing mod-2^32 sum word after the data.
module inst_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        inValid,
    input  logic [7:0]  inData,
    output logic        inReady,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memData,
    output logic        cpuHold,
    output logic        done,
    output logic        error
);
    localparam int IW = ADDR_WIDTH + 1;
    localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam loader_state_t END_ST = CSUM;
    logic [31:0] sum_q, sum_d;
`else
    localparam loader_state_t END_ST = DONE;
`endif
    loader_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, n_q, n_d;
    logic          in_ready_q, in_ready_d, mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
    logic          cpu_hold_q, cpu_hold_d, done_q, done_d, error_q, error_d;
    logic          accept, word_valid;
    logic [31:0]   word;
    assign accept = inValid && in_ready_q;
    word_assembler u_asm (
        .clk      (clk),
        .resetN   (resetN),
        .byteEn   (accept),
        .byteIn   (inData),
        .wordValid(word_valid),
        .word     (word)
    );
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= LEN;
        else         state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (word_valid) begin
            case (state_q)
                LEN:  state_d = (word == 32'd0) ? END_ST : ({1'b0, word} > CAP) ? ERROR : DATA;
                DATA: state_d = (idx_q + IW'(1) == n_q) ? END_ST : DATA;
`ifdef INST_LOADER_CHECKSUM_EN
                CSUM: state_d = (word == sum_q) ? DONE : ERROR;
`endif
                default: state_d = state_q;
            endcase
        end
    end
    // Ready is derived from the next state so it never lags the FSM.
    always_comb begin
        n_d        = (state_q == LEN && word_valid) ? word[IW-1:0] : n_q;
        mem_we_d   = (state_q == DATA) && word_valid;
        idx_d      = mem_we_d ? idx_q + IW'(1) : idx_q;
        mem_addr_d = mem_we_d ? 32'(idx_q) << 2 : mem_addr_q;
        mem_data_d = mem_we_d ? word : mem_data_q;
        in_ready_d = state_d inside {LEN, DATA, CSUM};
        done_d     = state_d == DONE;
        error_d    = state_d == ERROR;
        cpu_hold_d = state_d != DONE;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d      = mem_we_d ? sum_q + word : sum_q;
`endif
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idx_q      <= '0;
            n_q        <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_data_q <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            idx_q      <= idx_d;
            n_q        <= n_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end
    assign inReady = in_ready_q;
    assign memWe   = mem_we_q;
    assign memAddr = mem_addr_q;
    assign memData = mem_data_q;
    assign cpuHold = cpu_hold_q;
    assign done    = done_q;
    assign error   = error_q;
endmodule
